// File: rtl/ysyx_22041752_sram_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) in front of one
// shared SRAM port. Data requests normally win. The fetch side is guaranteed
// a grant after STARVE_LIMIT consecutive data grants taken while it waited.
// At most one SRAM transaction is outstanding. The request fields come only
// from registers latched at grant time.
module ysyx_22041752_sram_arbiter #(
    parameter int ADDR_WD      = 32,
    parameter int DATA_WD      = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 inst_en,
    input  logic [ADDR_WD-1:0]   inst_addr,
    output logic                 inst_ready,
    output logic [DATA_WD-1:0]   inst_rdata,
    output logic                 inst_valid,

    input  logic                 data_en,
    input  logic                 data_wen,
    input  logic [DATA_WD/8-1:0] data_wstrb,
    input  logic [ADDR_WD-1:0]   data_addr,
    input  logic [DATA_WD-1:0]   data_wdata,
    output logic                 data_ready,
    output logic [DATA_WD-1:0]   data_rdata,
    output logic                 data_valid,

    output logic                 mem_en,
    output logic                 mem_wen,
    output logic [DATA_WD/8-1:0] mem_wstrb,
    output logic [ADDR_WD-1:0]   mem_addr,
    output logic [DATA_WD-1:0]   mem_wdata,
    input  logic                 mem_ready,
    input  logic [DATA_WD-1:0]   mem_rdata,
    input  logic                 mem_valid
);

    localparam int                CNT_WD     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WD-1:0] STARVE_MAX = CNT_WD'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        INST_REQ,
        INST_RESP,
        DATA_REQ,
        DATA_RESP
    } state_t;

    state_t                 state;
    logic [ADDR_WD-1:0]     addr_q;
    logic                   wen_q;
    logic [DATA_WD/8-1:0]   wstrb_q;
    logic [DATA_WD-1:0]     wdata_q;
    logic [CNT_WD-1:0]      starve_cnt;

    logic in_req;
    logic in_resp;
    logic arb_point;
    logic starved;
    logic grant_data;
    logic grant_inst;

    // Arbitration is evaluated when the port is free. That is either IDLE, or
    // the response cycle of the current transaction, which allows
    // back-to-back issue.
    assign in_req     = (state == INST_REQ) || (state == DATA_REQ);
    assign in_resp    = (state == INST_RESP) || (state == DATA_RESP);
    assign arb_point  = (state == IDLE) || (in_resp && mem_valid);
    assign starved    = inst_en && (starve_cnt == STARVE_MAX);
    assign grant_data = arb_point && data_en && !starved;
    assign grant_inst = arb_point && inst_en && !grant_data;

    // Handshake pulses are combinational in the accepting/responding cycle.
    // They are forced low while reset is asserted, so reset dominates.
    assign mem_en     = !reset && in_req && !mem_ready;
    assign inst_ready = !reset && (state == INST_REQ)  && mem_ready;
    assign data_ready = !reset && (state == DATA_REQ)  && mem_ready;
    assign inst_valid = !reset && (state == INST_RESP) && mem_valid;
    assign data_valid = !reset && (state == DATA_RESP) && mem_valid;

    // Read data is shared. Each consumer qualifies it with its own valid.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // The SRAM request fields never look at requester inputs directly.
    // This keeps them stable while the request waits for mem_ready.
    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;

    // FSM, grant latches and the starvation counter advance together.
    // NOTE: non-blocking assignments, so every register here sees pre-edge
    // values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            starve_cnt <= '0;
        end else if (arb_point) begin
            if (grant_data) begin
                state   <= DATA_REQ;
                addr_q  <= data_addr;
                wen_q   <= data_wen;
                wstrb_q <= data_wstrb;
                wdata_q <= data_wdata;
                if (!inst_en) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + CNT_WD'(1);
                end
            end else if (grant_inst) begin
                state      <= INST_REQ;
                addr_q     <= inst_addr;
                wen_q      <= 1'b0;
                wstrb_q    <= '0;
                wdata_q    <= '0;
                starve_cnt <= '0;
            end else begin
                state <= IDLE;
            end
        end else if (in_req && mem_ready) begin
            state <= (state == INST_REQ) ? INST_RESP : DATA_RESP;
        end
    end

endmodule

// File: tb/tb_ysyx_22041752_sram_arbiter.sv
// Self-checking bench for the SRAM arbiter. A transaction-level reference
// model tracks the port owner, whether its request has been accepted, the
// latched fields and the starvation count. All outputs are compared every
// cycle. Directed scenarios add explicit checks for the key behaviours, then
// a long randomized run follows.
module tb_ysyx_22041752_sram_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_en;
    logic [AW-1:0] inst_addr;
    logic          inst_ready;
    logic [DW-1:0] inst_rdata;
    logic          inst_valid;
    logic          data_en;
    logic          data_wen;
    logic [DW/8-1:0] data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_ready;
    logic [DW-1:0] data_rdata;
    logic          data_valid;
    logic          mem_en;
    logic          mem_wen;
    logic [DW/8-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;

    always #5 clk = ~clk;

    ysyx_22041752_sram_arbiter #(.ADDR_WD(AW), .DATA_WD(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_ready(inst_ready),
        .inst_rdata(inst_rdata), .inst_valid(inst_valid),
        .data_en(data_en), .data_wen(data_wen), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_ready(data_ready),
        .data_rdata(data_rdata), .data_valid(data_valid),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0 = free, 1 = inst, 2 = data.
    int            m_owner;
    bit            m_issued;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [DW/8-1:0] m_wstrb;
    logic [DW-1:0] m_wdata;
    int            m_starve;
    bit            model_known = 1'b0;

    // SRAM responder settings.
    bit            sram_auto = 1'b0;
    bit            rand_mode = 1'b0;
    int            req_cycles, resp_cycles, ready_dly, valid_dly;
    int            fix_ready_dly = 1;
    int            fix_valid_dly = 2;
    logic [DW-1:0] fix_rdata = 64'h13;

    // Observation bookkeeping.
    int            cnt_ir, cnt_iv, cnt_dr, cnt_dv, cyc, cyc_ir, cyc_dv;
    int            glog[$];
    logic [AW-1:0] cap_d_addr;
    logic          cap_d_wen;
    logic [DW-1:0] cap_iv_rdata;
    bit            wen_seen;
    bit            e_ir_prev = 1'b0;
    bit            e_dr_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        cnt_ir = 0; cnt_iv = 0; cnt_dr = 0; cnt_dv = 0;
        cyc_ir = -100; cyc_dv = -100;
        glog.delete();
        wen_seen = 1'b0;
    endtask

    task automatic model_reset();
        m_owner = 0; m_issued = 1'b0;
        m_addr = '0; m_wen = 1'b0; m_wstrb = '0; m_wdata = '0;
        m_starve = 0; req_cycles = 0; resp_cycles = 0;
        model_known = 1'b1;
    endtask

    task automatic drive_sram();
        bit rq;
        if (!sram_auto) return;
        rq = (m_owner != 0) && !m_issued;
        if (rq) mem_ready = (req_cycles >= ready_dly);
        else    mem_ready = rand_mode && ($urandom_range(0, 15) == 0);
        if (m_issued) mem_valid = (resp_cycles + 1 >= valid_dly);
        else          mem_valid = rand_mode && ($urandom_range(0, 15) == 0);
        mem_rdata = rand_mode ? {$urandom(), $urandom()} : fix_rdata;
    endtask

    // One clock cycle. Inputs are driven before the call, right after the
    // falling edge. The task then compares outputs, crosses the rising edge,
    // advances the model and returns at the next falling edge.
    task automatic tick();
        bit rq, e_men, e_ir, e_dr, e_iv, e_dv, arb;
        int win;
        drive_sram();
        #1;
        rq    = (m_owner != 0) && !m_issued;
        e_men = !reset && rq && !mem_ready;
        e_ir  = !reset && rq && (m_owner == 1) && mem_ready;
        e_dr  = !reset && rq && (m_owner == 2) && mem_ready;
        e_iv  = !reset && m_issued && (m_owner == 1) && mem_valid;
        e_dv  = !reset && m_issued && (m_owner == 2) && mem_valid;
        if (model_known) begin
            chk("mem_en",     64'(mem_en),     64'(e_men));
            chk("inst_ready", 64'(inst_ready), 64'(e_ir));
            chk("data_ready", 64'(data_ready), 64'(e_dr));
            chk("inst_valid", 64'(inst_valid), 64'(e_iv));
            chk("data_valid", 64'(data_valid), 64'(e_dv));
            chk("mem_addr",   64'(mem_addr),   64'(m_addr));
            chk("mem_wen",    64'(mem_wen),    64'(m_wen));
            chk("mem_wstrb",  64'(mem_wstrb),  64'(m_wstrb));
            chk("mem_wdata",  64'(mem_wdata),  64'(m_wdata));
            chk("inst_rdata", 64'(inst_rdata), 64'(mem_rdata));
            chk("data_rdata", 64'(data_rdata), 64'(mem_rdata));
            chk("starve_cnt", 64'(dut.starve_cnt), 64'(m_starve));
        end
        if (inst_ready === 1'b1) begin cnt_ir++; glog.push_back(1); cyc_ir = cyc; end
        if (data_ready === 1'b1) begin
            cnt_dr++; glog.push_back(2); cap_d_addr = mem_addr; cap_d_wen = mem_wen;
        end
        if (inst_valid === 1'b1) begin cnt_iv++; cap_iv_rdata = inst_rdata; end
        if (data_valid === 1'b1) begin cnt_dv++; cyc_dv = cyc; end
        if (mem_wen === 1'b1) wen_seen = 1'b1;
        e_ir_prev = e_ir;
        e_dr_prev = e_dr;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            arb = (m_owner == 0) || (m_issued && mem_valid);
            if (arb) begin
                if (data_en && !(inst_en && m_starve == SL)) win = 2;
                else if (inst_en)                            win = 1;
                else                                         win = 0;
                m_owner = win; m_issued = 1'b0; req_cycles = 0; resp_cycles = 0;
                if (win == 2) begin
                    m_addr = data_addr; m_wen = data_wen; m_wstrb = data_wstrb; m_wdata = data_wdata;
                    m_starve = inst_en ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                end else if (win == 1) begin
                    m_addr = inst_addr; m_wen = 1'b0; m_wstrb = '0; m_wdata = '0;
                    m_starve = 0;
                end
                ready_dly = rand_mode ? int'($urandom_range(0, 2)) : fix_ready_dly;
                valid_dly = rand_mode ? int'($urandom_range(1, 3)) : fix_valid_dly;
            end else if (rq && mem_ready) begin
                m_issued = 1'b1; resp_cycles = 0;
            end else begin
                if (rq) req_cycles++;
                if (m_issued) resp_cycles++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Lets outstanding work finish, dropping each request once accepted.
    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (e_ir_prev) inst_en = 1'b0;
            if (e_dr_prev) data_en = 1'b0;
            if (m_owner == 0 && !inst_en && !data_en) break;
            tick();
        end
    endtask

    int  exp_order[5] = '{2, 2, 2, 2, 1};
    int  snap_iv, snap_ir, snap_dr, snap_dv;
    bit  starve_checked;

    initial begin
        reset = 1'b1;
        inst_en = 1'b0; inst_addr = '0;
        data_en = 1'b0; data_wen = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        cyc = 0;
        clear_obs();
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mem_en",   64'(mem_en),   64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_mem_wen",  64'(mem_wen),  64'h0);
        chk("rst_pulses",   64'({inst_ready, inst_valid, data_ready, data_valid}), 64'h0);
        chk("rst_starve",   64'(dut.starve_cnt), 64'h0);
        @(negedge clk);

        // Instruction fetch only.
        sram_auto = 1'b1; rand_mode = 1'b0;
        fix_ready_dly = 1; fix_valid_dly = 2; fix_rdata = 64'h13;
        clear_obs();
        inst_en = 1'b1; inst_addr = 32'h8000_0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cnt_ir > 0) inst_en = 1'b0;
        end
        chk("fetch_ready_cnt", 64'(cnt_ir), 64'd1);
        chk("fetch_valid_cnt", 64'(cnt_iv), 64'd1);
        chk("fetch_rdata",     cap_iv_rdata, 64'h13);
        chk("fetch_wen_low",   64'(wen_seen), 64'd0);

        // Simultaneous requests: store wins, fetch follows with no bubble.
        clear_obs();
        inst_en = 1'b1; inst_addr = 32'h8000_0000;
        data_en = 1'b1; data_wen = 1'b1; data_addr = 32'h8000_1000;
        data_wstrb = 8'hFF; data_wdata = 64'h1122_3344_5566_7788;
        for (int i = 0; i < 20 && cnt_iv == 0; i++) begin
            tick();
            if (cnt_dr > 0) data_en = 1'b0;
            if (cnt_ir > 0) inst_en = 1'b0;
        end
        chk("both_order_len", 64'(glog.size() >= 2), 64'd1);
        if (glog.size() >= 2) begin
            chk("both_first_data", 64'(glog[0]), 64'd2);
            chk("both_then_inst",  64'(glog[1]), 64'd1);
        end
        chk("both_store_addr", 64'(cap_d_addr), 64'h8000_1000);
        chk("both_store_wen",  64'(cap_d_wen),  64'd1);
        chk("both_no_bubble",  64'(cyc_ir - cyc_dv), 64'd2);
        drain();

        // Continuous data traffic against a waiting fetch.
        clear_obs();
        starve_checked = 1'b0;
        inst_en = 1'b1; inst_addr = 32'h8000_0100;
        data_en = 1'b1; data_wen = 1'b0; data_addr = 32'h8000_3000; data_wstrb = '0;
        for (int i = 0; i < 80 && cnt_iv == 0; i++) begin
            tick();
            if (cnt_ir > 0 && !starve_checked) begin
                chk("starve_cleared", 64'(dut.starve_cnt), 64'd0);
                starve_checked = 1'b1;
                inst_en = 1'b0;
            end
        end
        chk("starve_order_len", 64'(glog.size() >= 5), 64'd1);
        for (int k = 0; k < 5 && k < glog.size(); k++)
            chk("starve_order", 64'(glog[k]), 64'(exp_order[k]));
        drain();

        // Address changes after the grant do not reach the SRAM.
        clear_obs();
        fix_ready_dly = 3; fix_valid_dly = 1;
        data_en = 1'b1; data_wen = 1'b0; data_addr = 32'h8000_2000;
        tick();
        data_addr = 32'h1234_5678;
        tick();
        #1;
        chk("hold_mem_en",   64'(mem_en),   64'd1);
        chk("hold_mem_addr", 64'(mem_addr), 64'h8000_2000);
        for (int i = 0; i < 12 && cnt_dv == 0; i++) begin
            tick();
            if (cnt_dr > 0) data_en = 1'b0;
        end
        chk("hold_ready_addr", 64'(cap_d_addr), 64'h8000_2000);
        chk("hold_done",       64'(cnt_dv), 64'd1);
        drain();

        // Reset in the middle of a fetch, then a stray response.
        clear_obs();
        sram_auto = 1'b0;
        mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 64'h55;
        inst_en = 1'b1; inst_addr = 32'h8000_0040;
        tick();
        tick();
        mem_ready = 1'b1;
        tick();
        inst_en = 1'b0; mem_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_valid = 1'b1;
        #1;
        chk("abort_inst_valid", 64'(inst_valid), 64'd0);
        chk("abort_mem_en",     64'(mem_en),     64'd0);
        chk("abort_mem_addr",   64'(mem_addr),   64'h0);
        chk("abort_fields",     64'({mem_wen, mem_wstrb}), 64'h0);
        chk("abort_mem_wdata",  mem_wdata,       64'h0);
        tick();
        mem_valid = 1'b0;
        tick();
        chk("abort_no_valid", 64'(cnt_iv), 64'd0);

        // Stray SRAM handshakes while idle.
        snap_ir = cnt_ir; snap_iv = cnt_iv; snap_dr = cnt_dr; snap_dv = cnt_dv;
        mem_valid = 1'b1; mem_ready = 1'b1;
        repeat (3) tick();
        mem_valid = 1'b0; mem_ready = 1'b0;
        chk("stray_pulses", 64'(cnt_ir + cnt_iv + cnt_dr + cnt_dv),
            64'(snap_ir + snap_iv + snap_dr + snap_dv));
        #1;
        chk("stray_idle_mem_en", 64'(mem_en), 64'd0);
        @(negedge clk);

        // Randomized traffic with random SRAM latency, strays and one reset.
        sram_auto = 1'b1; rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            reset = (i == 1500);
            if (!inst_en) begin
                if ($urandom_range(0, 2) == 0) begin inst_en = 1'b1; inst_addr = $urandom(); end
            end else if (e_ir_prev) begin
                inst_en = ($urandom_range(0, 1) == 1); inst_addr = $urandom();
            end else if ($urandom_range(0, 15) == 0) begin
                inst_en = 1'b0;
            end
            if (!data_en || e_dr_prev || $urandom_range(0, 7) == 0) begin
                data_wen = ($urandom_range(0, 1) == 1);
                data_addr = $urandom();
                data_wstrb = 8'($urandom_range(0, 255));
                data_wdata = {$urandom(), $urandom()};
            end
            if (!data_en) data_en = ($urandom_range(0, 2) == 0);
            else if (e_dr_prev) data_en = ($urandom_range(0, 1) == 1);
            else if ($urandom_range(0, 15) == 0) data_en = 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
